// File: rtl/integration_pkg.sv
// Shared AHB arbitration types and widths for the parametrised arbiter slice.
package integration_pkg;

    localparam int unsigned HMASTER_W = 4;
    localparam int unsigned BEAT_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Only NONSEQ and SEQ move data and count towards a tenure.
    function automatic logic is_data_beat(htrans_e t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/ahb_param_arbiter_if.sv
// Request/grant bundle between AHB masters and the arbiter.
interface ahb_param_arbiter_if
    import integration_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    htrans_e                htrans;
    logic                   hready;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [HMASTER_W-1:0]   hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hready,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hready,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_arb_picker.sv
// Combinational winner search: lowest index (fixed) or first requester from start upward (round-robin).
module ahb_arb_picker
    import integration_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [HMASTER_W-1:0]   start,
    input  arb_mode_e              mode,
    output logic [HMASTER_W-1:0]   winner,
    output logic                   valid
);
    localparam int unsigned N = NUM_MASTERS;

    logic [HMASTER_W-1:0] base;
    logic [2*N-1:0]       dbl;
    logic [N-1:0]         rot;

    // Rotate the request vector so bit 0 is the first candidate in search order.
    assign base = (mode == ARB_RR) ? HMASTER_W'(32'(start) % N) : '0;
    assign dbl  = {req, req};
    assign rot  = N'(dbl >> base);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                winner = HMASTER_W'((32'(base) + 32'(k)) % N);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_param_arbiter.sv
// AHB arbiter for 2..16 masters: fixed-priority or round-robin with burst limit, lock hold
// and a default master; grant and handover registers update only on hready edges.
module ahb_param_arbiter
    import integration_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned MODE           = 0,
    parameter int unsigned DEFAULT_MASTER = NUM_MASTERS - 1,
    parameter logic [7:0]  BURST_LIMIT    = 8'd0
) (
    input logic                hclk,
    input logic                hreset,
    ahb_param_arbiter_if.slave bus
);
    localparam int unsigned          N         = NUM_MASTERS;
    localparam arb_mode_e            ARB_MODE  = (MODE == 1) ? ARB_RR : ARB_FIXED;
    localparam logic [HMASTER_W-1:0] DEF_IDX   = HMASTER_W'(DEFAULT_MASTER);
    localparam logic [N-1:0]         DEF_GRANT = N'(1) << DEFAULT_MASTER;
    localparam logic [BEAT_W-1:0]    BEAT_MAX  = '1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
        $error("ahb_param_arbiter: NUM_MASTERS must be within 2..16");
    end
    if (MODE > 1) begin : g_bad_mode
        $error("ahb_param_arbiter: MODE must be 0 or 1");
    end
    if (DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_default
        $error("ahb_param_arbiter: DEFAULT_MASTER must be below NUM_MASTERS");
    end

    logic [N-1:0]         grant_q;
    logic [HMASTER_W-1:0] gidx_q;
    logic [HMASTER_W-1:0] hmaster_q;
    logic                 hmastlock_q;
    logic [BEAT_W-1:0]    beat_q;

    logic                 owner_req_c;
    logic                 owner_hold_c;
    logic                 owner_hlock_c;
    logic                 under_limit_c;
    logic                 beat_inc_c;
    logic [HMASTER_W-1:0] pick_idx_c;
    logic                 pick_valid_c;
    logic [HMASTER_W-1:0] next_idx_c;
    logic [N-1:0]         next_grant_c;
    logic                 beat_clr_c;

    // Grant is one-hot, so masking with it selects the owner's request/lock bits.
    assign owner_req_c   = |(bus.hbusreq & grant_q);
    assign owner_hlock_c = |(bus.hlock & grant_q);
    assign owner_hold_c  = |(bus.hbusreq & bus.hlock & grant_q);
    assign under_limit_c = (BURST_LIMIT == 8'd0) || (beat_q < BURST_LIMIT);
    assign beat_inc_c    = is_data_beat(bus.htrans) && (hmaster_q == gidx_q);

    ahb_arb_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req    (bus.hbusreq),
        .start  (gidx_q + HMASTER_W'(1)),
        .mode   (ARB_MODE),
        .winner (pick_idx_c),
        .valid  (pick_valid_c)
    );

    // Next owner; a round-robin search that lands back on the owner means it is the sole requester.
    always_comb begin
        next_idx_c = gidx_q;
        beat_clr_c = 1'b0;
        if (owner_hold_c) begin
            next_idx_c = gidx_q;
        end else if (!pick_valid_c) begin
            next_idx_c = DEF_IDX;
        end else if (ARB_MODE == ARB_FIXED) begin
            next_idx_c = pick_idx_c;
        end else if (owner_req_c && under_limit_c) begin
            next_idx_c = gidx_q;
        end else begin
            next_idx_c = pick_idx_c;
            beat_clr_c = (pick_idx_c == gidx_q);
        end
        next_grant_c = N'(1) << next_idx_c;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            grant_q     <= DEF_GRANT;
            gidx_q      <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            beat_q      <= '0;
        end else if (bus.hready) begin
            grant_q     <= next_grant_c;
            gidx_q      <= next_idx_c;
            hmaster_q   <= gidx_q;
            hmastlock_q <= owner_hlock_c;
            if (next_idx_c != gidx_q || beat_clr_c) begin
                beat_q <= '0;
            end else if (beat_inc_c && beat_q != BEAT_MAX) begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    assign bus.hgrant    = grant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_param_arbiter.sv
// Bench for ahb_param_arbiter: a fixed-priority and a round-robin (limit 4) instance share stimulus.
module tb_ahb_param_arbiter;
    import integration_pkg::*;

    localparam int unsigned NM    = 4;
    localparam int unsigned DEF   = 3;
    localparam int unsigned LIMIT = 4;

    logic       hclk;
    logic       hreset;
    logic [3:0] req;
    logic [3:0] lk;
    htrans_e    tr;
    logic       rdy;

    int n_checks;
    int n_fail;

    ahb_param_arbiter_if #(.NUM_MASTERS(NM)) if_fix ();
    ahb_param_arbiter_if #(.NUM_MASTERS(NM)) if_rr ();

    assign if_fix.hbusreq = req;
    assign if_fix.hlock   = lk;
    assign if_fix.htrans  = tr;
    assign if_fix.hready  = rdy;
    assign if_rr.hbusreq  = req;
    assign if_rr.hlock    = lk;
    assign if_rr.htrans   = tr;
    assign if_rr.hready   = rdy;

    ahb_param_arbiter #(
        .NUM_MASTERS(NM), .MODE(0), .DEFAULT_MASTER(DEF), .BURST_LIMIT(8'd0)
    ) u_fix (
        .hclk(hclk), .hreset(hreset), .bus(if_fix)
    );

    ahb_param_arbiter #(
        .NUM_MASTERS(NM), .MODE(1), .DEFAULT_MASTER(DEF), .BURST_LIMIT(8'd4)
    ) u_rr (
        .hclk(hclk), .hreset(hreset), .bus(if_rr)
    );

    logic [3:0] o_grant [2];
    logic [3:0] o_master[2];
    logic       o_lock  [2];
    assign o_grant[0]  = if_fix.hgrant;
    assign o_grant[1]  = if_rr.hgrant;
    assign o_master[0] = if_fix.hmaster;
    assign o_master[1] = if_rr.hmaster;
    assign o_lock[0]   = if_fix.hmastlock;
    assign o_lock[1]   = if_rr.hmastlock;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Reference model: index 0 = fixed priority, index 1 = round-robin with LIMIT beats.
    int unsigned m_g    [2];
    int unsigned m_m    [2];
    bit          m_l    [2];
    int unsigned m_beats[2];

    function automatic int unsigned next_owner(int d);
        int unsigned g;
        g = m_g[d];
        if (req == 4'b0) return DEF;
        if (req[g] && lk[g]) return g;
        if (d == 0) begin
            for (int i = 0; i < NM; i++) if (req[i]) return i;
        end
        if (req[g] && m_beats[d] < LIMIT) return g;
        for (int k = 1; k <= NM; k++) if (req[(g + k) % NM]) return (g + k) % NM;
        return g;
    endfunction

    function automatic int unsigned next_beats(int d);
        int unsigned g;
        int unsigned others;
        g = m_g[d];
        others = 0;
        for (int i = 0; i < NM; i++) if (i != g && req[i]) others++;
        if (next_owner(d) != g) return 0;
        if (d == 1 && !(req[g] && lk[g]) && !(req[g] && m_beats[d] < LIMIT) && others == 0 && req[g])
            return 0;
        if ((tr == NONSEQ || tr == SEQ) && m_m[d] == g) return (m_beats[d] >= 255) ? 255 : m_beats[d] + 1;
        return m_beats[d];
    endfunction

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int d = 0; d < 2; d++) begin
                m_g[d]     <= DEF;
                m_m[d]     <= DEF;
                m_l[d]     <= 1'b0;
                m_beats[d] <= 0;
            end
        end else if (rdy) begin
            for (int d = 0; d < 2; d++) begin
                m_g[d]     <= next_owner(d);
                m_m[d]     <= m_g[d];
                m_l[d]     <= lk[m_g[d]];
                m_beats[d] <= next_beats(d);
            end
        end
    end

    function automatic int oh2idx(logic [3:0] v);
        for (int i = 0; i < NM; i++) if (v == (4'b0001 << i)) return i;
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge hclk);
        hreset = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    task automatic test_reset();
        hreset = 1'b1; req = '0; lk = '0; tr = IDLE; rdy = 1'b1;
        for (int phase = 0; phase < 2; phase++) begin
            repeat (2) @(negedge hclk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (o_grant[d] !== 4'b1000) begin
                    n_fail++; $display("FAIL reset_grant dut%0d phase%0d got %b want 1000", d, phase, o_grant[d]);
                end
                n_checks++;
                if (o_master[d] !== 4'd3) begin
                    n_fail++; $display("FAIL reset_hmaster dut%0d phase%0d got %0d want 3", d, phase, o_master[d]);
                end
                n_checks++;
                if (o_lock[d] !== 1'b0) begin
                    n_fail++; $display("FAIL reset_hmastlock dut%0d phase%0d got %b want 0", d, phase, o_lock[d]);
                end
            end
            hreset = 1'b0;
        end
    endtask

    task automatic test_fixed_preempt();
        req = 4'b0110; tr = NONSEQ;
        @(negedge hclk);
        n_checks++;
        if (o_grant[0] !== 4'b0010) begin
            n_fail++; $display("FAIL preempt_first_grant got %b want 0010", o_grant[0]);
        end
        req = 4'b0111;
        @(negedge hclk);
        n_checks++;
        if (o_grant[0] !== 4'b0001) begin
            n_fail++; $display("FAIL preempt_grant got %b want 0001", o_grant[0]);
        end
        n_checks++;
        if (o_grant[1] !== 4'b0010) begin
            n_fail++; $display("FAIL rr_no_preempt got %b want 0010", o_grant[1]);
        end
        @(negedge hclk);
        n_checks++;
        if (o_master[0] !== 4'd0) begin
            n_fail++; $display("FAIL preempt_hmaster got %0d want 0", o_master[0]);
        end
    endtask

    task automatic test_lock_hold();
        req = 4'b0100; lk = 4'b0100;
        repeat (2) @(negedge hclk);
        req = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            n_checks++;
            if (o_grant[0] !== 4'b0100) begin
                n_fail++; $display("FAIL lock_grant cyc%0d got %b want 0100", c, o_grant[0]);
            end
            n_checks++;
            if (o_lock[0] !== 1'b1) begin
                n_fail++; $display("FAIL lock_hmastlock cyc%0d got %b want 1", c, o_lock[0]);
            end
        end
        lk = 4'b0000;
        @(negedge hclk);
        n_checks++;
        if (o_grant[0] !== 4'b0001) begin
            n_fail++; $display("FAIL lock_release_grant got %b want 0001", o_grant[0]);
        end
        n_checks++;
        if (o_lock[0] !== 1'b0) begin
            n_fail++; $display("FAIL lock_release_hmastlock got %b want 0", o_lock[0]);
        end
    endtask

    task automatic test_rr_rotation();
        int exp_seq[4];
        int seen[$];
        int len[$];
        int prev;
        int cur;
        int run;
        exp_seq = '{0, 1, 3, 0};
        lk = '0;
        apply_reset();
        req = 4'b1011; rdy = 1'b1;
        prev = 3; run = 0;
        for (int c = 0; c < 80 && seen.size() < 4; c++) begin
            tr = ($urandom_range(0, 1) == 0) ? NONSEQ : SEQ;
            @(negedge hclk);
            n_checks++;
            if (o_grant[1] !== 4'(1 << m_g[1])) begin
                n_fail++; $display("FAIL rr_grant_model cyc%0d got %b want %b", c, o_grant[1], 4'(1 << m_g[1]));
            end
            cur = oh2idx(o_grant[1]);
            if (cur != prev) begin
                seen.push_back(cur);
                if (seen.size() > 1) len.push_back(run);
                prev = cur; run = 1;
            end else begin
                run++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= seen.size() || seen[i] != exp_seq[i]) begin
                n_fail++; $display("FAIL rr_order step%0d got %0d want %0d", i, (i < seen.size()) ? seen[i] : -1, exp_seq[i]);
            end
        end
        // 6 grant cycles = 4 counted beats + grant-to-ownership cycle + handover edge.
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= len.size() || len[i] != 6) begin
                n_fail++; $display("FAIL rr_tenure_len tenure%0d got %0d want 6", i, (i < len.size()) ? len[i] : -1);
            end
        end
    endtask

    task automatic test_wait_states();
        lk = '0; tr = NONSEQ;
        apply_reset();
        req = 4'b0100;
        repeat (2) @(negedge hclk);
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0011 : 4'b0000;
            @(negedge hclk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (o_grant[d] !== 4'b0100) begin
                    n_fail++; $display("FAIL wait_grant dut%0d cyc%0d got %b want 0100", d, c, o_grant[d]);
                end
                n_checks++;
                if (o_master[d] !== 4'd2) begin
                    n_fail++; $display("FAIL wait_hmaster dut%0d cyc%0d got %0d want 2", d, c, o_master[d]);
                end
            end
        end
        req = 4'b0001; rdy = 1'b1;
        @(negedge hclk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_grant[d] !== 4'b0001) begin
                n_fail++; $display("FAIL wait_resume dut%0d got %b want 0001", d, o_grant[d]);
            end
        end
    endtask

    task automatic test_async_reset();
        req = 4'b0011; lk = 4'b0001; rdy = 1'b1; tr = SEQ;
        repeat (4) @(negedge hclk);
        @(posedge hclk);
        #3 hreset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_grant[d] !== 4'b1000 || o_master[d] !== 4'd3 || o_lock[d] !== 1'b0) begin
                n_fail++; $display("FAIL async_reset dut%0d got grant=%b hmaster=%0d lock=%b want 1000/3/0",
                                   d, o_grant[d], o_master[d], o_lock[d]);
            end
        end
        @(negedge hclk);
        hreset = 1'b0; rdy = 1'b0; req = 4'b0001; lk = '0;
        @(negedge hclk);
        n_checks++;
        if (o_grant[1] !== 4'b1000) begin
            n_fail++; $display("FAIL post_reset_stall got %b want 1000", o_grant[1]);
        end
        rdy = 1'b1;
        @(negedge hclk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (o_grant[d] !== 4'b0001) begin
                n_fail++; $display("FAIL post_reset_first_arb dut%0d got %b want 0001", d, o_grant[d]);
            end
        end
    endtask

    task automatic test_random(int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge hclk);
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (o_grant[d] !== 4'(1 << m_g[d]) || !$onehot(o_grant[d])) begin
                    n_fail++; $display("FAIL rand_grant dut%0d cyc%0d got %b want %b", d, c, o_grant[d], 4'(1 << m_g[d]));
                end
                n_checks++;
                if (o_master[d] !== 4'(m_m[d])) begin
                    n_fail++; $display("FAIL rand_hmaster dut%0d cyc%0d got %0d want %0d", d, c, o_master[d], m_m[d]);
                end
                n_checks++;
                if (o_lock[d] !== m_l[d]) begin
                    n_fail++; $display("FAIL rand_hmastlock dut%0d cyc%0d got %b want %b", d, c, o_lock[d], m_l[d]);
                end
            end
            req = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
            lk  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            tr  = htrans_e'(2'($urandom_range(0, 3)));
            rdy = ($urandom_range(0, 4) != 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fixed_preempt();
        test_lock_hold();
        test_rr_rotation();
        test_wait_states();
        test_async_reset();
        test_random(600);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_param_arbiter.md
# ahb_param_arbiter

Parametrised AHB bus arbiter for up to 16 masters, the next generation of the fixed request/grant logic checked by the master-agent request interface. It samples per-master `hbusreq`/`hlock`, drives a one-hot `hgrant`, and registers `hmaster`/`hmastlock` on the AHB handover edge. It adds:
- selectable fixed-priority or round-robin arbitration;
- a per-tenure burst-beat limit;
- a configurable default master.

## Interface
- `NUM_MASTERS`, 4: number of masters; legal range 2..16. Any other value is an elaboration error.
- `MODE`, 0: 0 = fixed priority, master 0 highest, preemptive; 1 = round-robin.
- `DEFAULT_MASTER`, `NUM_MASTERS-1`: owner when no master requests.
- `BURST_LIMIT`, 0: MODE 1 only. Maximum data beats per tenure; 0 = unlimited. Width 8 bits.
- `hclk` in 1: single clock; all logic is on the rising edge.
- `hreset` in 1: asynchronous, active-high reset.
- `hbusreq` in `NUM_MASTERS`: bus request, one bit per master.
- `hlock` in `NUM_MASTERS`: locked-transfer request, one bit per master.
- `htrans` in 2: transfer type of the current bus owner. IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hready` in 1: transfer-complete signal from the slave mux.
- `hgrant` out `NUM_MASTERS`: one-hot grant, registered.
- `hmaster` out 4: current address-phase owner index, registered.
- `hmastlock` out 1: the owner's transfer is locked, registered.

## Operation
- **Reset values:**
  - `hgrant = 1 << DEFAULT_MASTER`
  - `hmaster = DEFAULT_MASTER`
  - `hmastlock = 0`
  - beat counter = 0
  - round-robin pointer = `DEFAULT_MASTER`
- **Arbitration point:** any rising edge with `hready=1`. With `hready=0`, every register holds.
- **Lock hold:** if `hlock[g]=1` and `hbusreq[g]=1` for the granted master g, g keeps the grant whatever the other requests are. `hlock` without `hbusreq` is ignored.
- **MODE 0:** the lowest-index requesting master wins at every arbitration point. A higher-priority master preempts the owner unless the lock hold applies.
- **MODE 1 (round-robin):**
  - The owner keeps the grant while it requests and beat count < `BURST_LIMIT` (or `BURST_LIMIT=0`).
  - Otherwise the grant goes to the first requester searching from g+1 upward, wrapping modulo `NUM_MASTERS`.
  - If no other master requests, the owner retains the grant and the counter clears.
- **Beat counter:** increments on `hready=1` with `htrans` = NONSEQ or SEQ while `hmaster == g`. It saturates at 255 and clears when the grant changes.
- **No requests:** `hgrant` goes to `DEFAULT_MASTER`.
- **Handover:** on each `hready=1` edge:
  - `hmaster <= index(hgrant)`
  - `hmastlock <= hlock[index(hgrant)]`
- **Invariant:** `$onehot(hgrant)` holds in every cycle after reset.

## Timing
- Request to grant: `hbusreq` is sampled at an arbitration edge and `hgrant` updates at that same edge, giving 1 cycle of latency.
- Grant to ownership: `hmaster` equals n one cycle after the first edge where `hgrant[n]=1` and `hready=1`.
- `hmastlock` follows `hgrant` with the same 1-cycle registration.
- Wait states (`hready=0`) stretch both steps. A `hbusreq` drop during wait states has no effect until the next arbitration edge.
- Simultaneous requests in MODE 1 resolve purely by pointer order. The `BURST_LIMIT` expiry and a new request arriving on the same edge cause a handover at that edge.
- Reset mid-burst returns all outputs to their reset values immediately (asynchronous). The first arbitration occurs at the first `hready=1` edge after reset release.

## Structure
- `integration_pkg` holds:
  - `htrans_e` (IDLE/BUSY/NONSEQ/SEQ);
  - `arb_mode_e` (`ARB_FIXED`, `ARB_RR`);
  - `HMASTER_W = 4`.
- Sub-module `ahb_arb_picker` is combinational. Inputs: request vector, start index, mode. Output: winner index and a valid flag. The parent holds all registers, the counter and the lock logic.

## Test plan
- **Reset:** `NUM_MASTERS=4`, `DEFAULT_MASTER=3`, no requests → `hgrant=4'b1000`, `hmaster=3`, `hmastlock=0`, both during and after reset.
- **MODE 0 preemption:** masters 2 and 1 request with `hready=1` → next edge `hgrant=4'b0010`. Master 0 raises `hbusreq` → `hgrant=4'b0001` one cycle later, and `hmaster=0` one cycle after that.
- **Lock hold:** master 2 owns the bus with `hlock[2]=1` and `hbusreq[2]=1`, and master 0 requests → `hgrant` stays `4'b0100` and `hmastlock=1` until master 2 drops `hlock`.
- **MODE 1, `BURST_LIMIT=4`:** masters 0, 1 and 3 request continuously with NONSEQ/SEQ and `hready=1` → grants rotate 0→1→3→0, each tenure lasting 4 beats.
- **Wait states:** `hready=0` for 3 cycles while `hbusreq` changes → `hgrant`/`hmaster` frozen. Arbitration resumes on the first `hready=1` edge.
- **Async reset mid-transfer:** assert `hreset` between clock edges → outputs reach their reset values before the next `hclk` edge.
